switch_alloc_vc: RTL

- Separable input-first switch allocator with round-robin arbitration and wormhole output locking.
- Sits directly upstream of the VC crossbar in each router.
- Takes per-VC flit requests from the input VC buffers and produces registered p_sel/vc_sel crossbar controls and per-VC grants back to the buffers.
- Grants and controls are aligned with the cycle in which the buffers drive the granted flit.

---
 rtl/switch_alloc_vc.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/switch_alloc_vc.sv
// Separable input-first switch allocator: round-robin VC and input stages, wormhole output locks.
// Optional SA_PERF_CNT_EN adds saturating per-output grant counters on port grant_cnt.
module switch_alloc_vc #(
    parameter int NUM_PORTS  = 5,
    parameter int NUM_VCS    = 4,
    parameter int VC_ID_BITS = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]         req_valid,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][2:0]    req_port,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]         req_tail,
    input  logic [NUM_PORTS-1:0]                      out_credit_ok,
    output logic [NUM_PORTS-1:0][NUM_VCS-1:0]         gnt,
    output logic [NUM_PORTS-1:0]                      out_valid,
    output logic [NUM_PORTS-1:0][1:0]                 p_sel,
    output logic [NUM_PORTS-1:0][VC_ID_BITS-1:0]      vc_sel
`ifdef SA_PERF_CNT_EN
    ,
    output logic [NUM_PORTS-1:0][15:0]                grant_cnt
`endif
);

    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] vc_ptr;
    logic [NUM_PORTS-1:0][2:0]            in_ptr;
    logic [NUM_PORTS-1:0]                 lock_valid;
    logic [NUM_PORTS-1:0][2:0]            lock_ip;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] lock_vc;

    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    elig;
    logic [NUM_PORTS-1:0]                 s1_found;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0] s1_vc;
    logic [NUM_PORTS-1:0][2:0]            s1_port;
    logic [NUM_PORTS-1:0]                 s1_tail;
    logic [NUM_PORTS-1:0]                 win_found;
    logic [NUM_PORTS-1:0][2:0]            win_ip;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]    gnt_d;

    // A VC may only bid for an output that is free or already locked to it.
    always_comb begin
        elig = '0;
        for (int ip = 0; ip < NUM_PORTS; ip++) begin
            for (int vc = 0; vc < NUM_VCS; vc++) begin
                if (req_valid[ip][vc] && !gnt[ip][vc] &&
                    req_port[ip][vc] != 3'(ip) &&
                    req_port[ip][vc] < 3'(NUM_PORTS)) begin
                    if (out_credit_ok[req_port[ip][vc]] &&
                        (!lock_valid[req_port[ip][vc]] ||
                         (lock_ip[req_port[ip][vc]] == 3'(ip) &&
                          lock_vc[req_port[ip][vc]] == VC_ID_BITS'(vc))))
                        elig[ip][vc] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        int idx;
        idx      = 0;
        s1_found = '0;
        s1_vc    = '0;
        s1_port  = '0;
        s1_tail  = '0;
        for (int ip = 0; ip < NUM_PORTS; ip++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
                idx = (int'(vc_ptr[ip]) + k) % NUM_VCS;
                if (!s1_found[ip] && elig[ip][idx]) begin
                    s1_found[ip] = 1'b1;
                    s1_vc[ip]    = VC_ID_BITS'(idx);
                end
            end
            s1_port[ip] = req_port[ip][s1_vc[ip]];
            s1_tail[ip] = req_tail[ip][s1_vc[ip]];
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        win_found = '0;
        win_ip    = '0;
        gnt_d     = '0;
        for (int op = 0; op < NUM_PORTS; op++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(in_ptr[op]) + k) % NUM_PORTS;
                if (!win_found[op] && s1_found[idx] &&
                    s1_port[idx] == 3'(op)) begin
                    win_found[op] = 1'b1;
                    win_ip[op]    = 3'(idx);
                end
            end
            if (win_found[op])
                gnt_d[win_ip[op]][s1_vc[win_ip[op]]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            out_valid  <= '0;
            p_sel      <= '0;
            vc_sel     <= '0;
            vc_ptr     <= '0;
            in_ptr     <= '0;
            lock_valid <= '0;
            lock_ip    <= '0;
            lock_vc    <= '0;
        end else begin
            gnt       <= gnt_d;
            out_valid <= win_found;
            for (int op = 0; op < NUM_PORTS; op++) begin
                if (win_found[op]) begin
                    p_sel[op] <= (win_ip[op] < 3'(op)) ?
                                 win_ip[op][1:0] : 2'(win_ip[op] - 3'd1);
                    vc_sel[win_ip[op]] <= s1_vc[win_ip[op]];
                    vc_ptr[win_ip[op]] <=
                        (s1_vc[win_ip[op]] == VC_ID_BITS'(NUM_VCS - 1)) ?
                        '0 : s1_vc[win_ip[op]] + 1'b1;
                    in_ptr[op] <= (win_ip[op] == 3'(NUM_PORTS - 1)) ?
                                  3'd0 : win_ip[op] + 3'd1;
                    // Tail releases (or never takes) the lock; body/head holds it.
                    lock_valid[op] <= !s1_tail[win_ip[op]];
                    lock_ip[op]    <= win_ip[op];
                    lock_vc[op]    <= s1_vc[win_ip[op]];
                end
            end
        end
    end

`ifdef SA_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int op = 0; op < NUM_PORTS; op++) begin
                if (out_valid[op] && grant_cnt[op] != 16'hFFFF)
                    grant_cnt[op] <= grant_cnt[op] + 16'd1;
            end
        end
    end
`endif

endmodule
